// File: rtl/pingpong_sdpram.sv
// Ring of NBUF equal-sized buffers over one simple dual-port RAM. The writer fills and
// commits buffers, the reader drains and releases them, and each side owns its buffer alone.
module pingpong_sdpram #(
  parameter     MEM_STYLE = "block",
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 10,
  parameter int NBUF      = 2,
  parameter int RD_LAT    = 1
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic                     I_wr,
  input  logic [ASIZE-1:0]         I_waddr,
  input  logic [DSIZE-1:0]         I_wdata,
  input  logic [DSIZE/8-1:0]       I_wbe,
  input  logic                     I_wdone,
  output logic                     O_wready,
  output logic [$clog2(NBUF)-1:0]  O_wbuf,
  input  logic                     I_rd,
  input  logic [ASIZE-1:0]         I_raddr,
  input  logic                     I_rdone,
  output logic                     O_rready,
  output logic [$clog2(NBUF)-1:0]  O_rbuf,
  output logic [DSIZE-1:0]         O_rdata,
  output logic                     O_rvld,
  output logic [$clog2(NBUF):0]    O_cnt
);

  localparam int          BW    = $clog2(NBUF);
  localparam int unsigned NBE   = DSIZE / 8;
  localparam int          DEPTH = NBUF << ASIZE;
  localparam logic [BW:0] FULL  = (BW+1)'(NBUF);
  localparam logic [BW:0] ONE   = (BW+1)'(1);

  if ((DSIZE % 8) != 0 || DSIZE <= 0) begin : g_bad_dsize
    $error("pingpong_sdpram: DSIZE must be a positive multiple of 8");
  end
  if (NBUF != 2 && NBUF != 4) begin : g_bad_nbuf
    $error("pingpong_sdpram: NBUF must be 2 or 4");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rdlat
    $error("pingpong_sdpram: RD_LAT must be 1 or 2");
  end

  logic [BW-1:0] wptr_q, wptr_d;
  logic [BW-1:0] rptr_q, rptr_d;
  logic [BW:0]   cnt_q, cnt_d;

  logic wr_en, commit_en, rd_en, release_en;
  logic [BW+ASIZE-1:0] waddr_full, raddr_full;

  assign O_wready   = (cnt_q != FULL);
  assign O_rready   = (cnt_q != '0);
  assign O_wbuf     = wptr_q;
  assign O_rbuf     = rptr_q;
  assign O_cnt      = cnt_q;

  assign wr_en      = I_wr    & O_wready;
  assign commit_en  = I_wdone & O_wready;
  assign rd_en      = I_rd    & O_rready;
  assign release_en = I_rdone & O_rready;

  // Addresses use the pre-advance pointers, so a same-cycle write/read hits the buffer being handed over.
  assign waddr_full = {wptr_q, I_waddr};
  assign raddr_full = {rptr_q, I_raddr};

  always_comb begin
    wptr_d = wptr_q + BW'(commit_en);
    rptr_d = rptr_q + BW'(release_en);
    cnt_d  = cnt_q;
    case ({commit_en, release_en})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  (* ram_style = MEM_STYLE *) logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge I_clk) begin
    for (int unsigned i = 0; i < NBE; i++) begin
      if (wr_en && I_wbe[i]) begin
        mem_q[waddr_full][8*i +: 8] <= I_wdata[8*i +: 8];
      end
    end
  end

  logic [DSIZE-1:0] rd1_q;
  logic             vld1_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rd1_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= rd_en;
      if (rd_en) begin
        rd1_q <= mem_q[raddr_full];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DSIZE-1:0] rd2_q;
    logic             vld2_q;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        rd2_q  <= '0;
        vld2_q <= 1'b0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) begin
          rd2_q <= rd1_q;
        end
      end
    end

    assign O_rdata = rd2_q;
    assign O_rvld  = vld2_q;
  end else begin : g_lat1
    assign O_rdata = rd1_q;
    assign O_rvld  = vld1_q;
  end

endmodule
